// File: rtl/div_unit.sv
// ---------------------------------------------------------------------------
// div_unit -- multi-cycle radix-2 restoring divider for DIV / DIVU.
//
// One quotient bit is produced per BUSY cycle, so a WIDTH-bit divide spends
// WIDTH cycles in BUSY. A divide by zero finishes after a single BUSY cycle
// with lo = all ones and hi = dividend.
//
// Optional feature (compile-time macro):
//   DIV_EARLY_OUT_EN - a divide with |a| < |b| (b != 0) finishes after one
//                      BUSY cycle with lo = 0 and hi = a. Results are the same
//                      with or without the macro; only the latency differs.
//
// Ports:
//   clk        in   clock, rising-edge active
//   rst        in   asynchronous reset, active low
//   start      in   divide request, held high by the pipeline until ready
//   signed_div in   1 = DIV (two's complement), 0 = DIVU
//   annul      in   cancel of the in-flight or requested divide
//   a          in   dividend
//   b          in   divisor
//   stall      out  holds the pipeline while a divide is pending
//   ready      out  one-cycle completion pulse (hi/lo valid)
//   hi         out  remainder, held until the next accepted divide completes
//   lo         out  quotient, held until the next accepted divide completes
// ---------------------------------------------------------------------------
module div_unit #(
    parameter int WIDTH = 32
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             start,
    input  logic             signed_div,
    input  logic             annul,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    output logic             stall,
    output logic             ready,
    output logic [WIDTH-1:0] hi,
    output logic [WIDTH-1:0] lo
);

    localparam int CNT_W = (WIDTH > 1) ? $clog2(WIDTH) : 1;
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(WIDTH - 1);

    typedef enum logic [1:0] {
        IDLE,
        BUSY,
        DONE
    } stateT;

    stateT state;
    stateT stateNext;

    // Datapath state
    logic [CNT_W-1:0] count;
    logic [WIDTH-1:0] quoReg;       // dividend magnitude shifting out, quotient shifting in
    logic [WIDTH-1:0] remReg;       // partial remainder (always < divisor)
    logic [WIDTH-1:0] divisorReg;   // divisor magnitude
    logic [WIDTH-1:0] dividendRaw;  // dividend as presented, returned on div-by-zero / early out
    logic             negQuo;
    logic             negRem;

    // Combinational helpers
    logic             accept;
    logic [WIDTH-1:0] aMag;
    logic [WIDTH-1:0] bMag;
    logic [WIDTH:0]   remShift;
    logic [WIDTH:0]   diff;
    logic             qBit;
    logic [WIDTH-1:0] remNext;
    logic [WIDTH-1:0] quoNext;
    logic             divByZero;
    logic             earlyOut;
    logic             lastStep;
    logic             finish;
    logic [WIDTH-1:0] hiResult;
    logic [WIDTH-1:0] loResult;

    assign accept = (state == IDLE) && start && !annul;

    // Operand magnitudes; the most negative value maps onto itself, which is
    // the correct unsigned magnitude 2**(WIDTH-1).
    always_comb begin
        aMag = (signed_div && a[WIDTH-1]) ? ('0 - a) : a;
        bMag = (signed_div && b[WIDTH-1]) ? ('0 - b) : b;
    end

    // One restoring step: shift in the next dividend bit, subtract when it fits.
    always_comb begin
        remShift = {remReg, quoReg[WIDTH-1]};
        diff     = remShift - {1'b0, divisorReg};
        qBit     = !diff[WIDTH];
        remNext  = qBit ? diff[WIDTH-1:0] : remShift[WIDTH-1:0];
        quoNext  = {quoReg[WIDTH-2:0], qBit};
    end

    assign divByZero = (divisorReg == '0);
    assign lastStep  = (count == '0);

`ifdef DIV_EARLY_OUT_EN
    // quoReg still holds the untouched dividend magnitude only in the first
    // BUSY cycle, so the comparison is qualified by the counter.
    assign earlyOut = !divByZero && (count == CNT_LAST) && (quoReg < divisorReg);
`else
    assign earlyOut = 1'b0;
`endif

    assign finish = (state == BUSY) && !annul && (divByZero || earlyOut || lastStep);

    // Final result with signs applied; evaluated in the last BUSY cycle.
    always_comb begin
        if (divByZero) begin
            loResult = '1;
            hiResult = dividendRaw;
        end else if (earlyOut) begin
            loResult = '0;
            hiResult = dividendRaw;
        end else begin
            loResult = negQuo ? ('0 - quoNext) : quoNext;
            hiResult = negRem ? ('0 - remNext) : remNext;
        end
    end

    // State register
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state <= IDLE;
        end else begin
            state <= stateNext;
        end
    end

    // Next-state and control outputs
    always_comb begin
        stateNext = state;
        stall     = 1'b0;
        ready     = 1'b0;
        case (state)
            IDLE: begin
                stall = accept;
                if (accept) begin
                    stateNext = BUSY;
                end
            end
            BUSY: begin
                stall = 1'b1;
                if (annul) begin
                    stateNext = IDLE;
                end else if (divByZero || earlyOut || lastStep) begin
                    stateNext = DONE;
                end
            end
            DONE: begin
                // start is still high here for the same instruction; never re-accept.
                ready     = 1'b1;
                stateNext = IDLE;
            end
            default: begin
                stateNext = IDLE;
            end
        endcase
        // A held start must not raise stall while reset is asserted.
        stall = stall && rst;
    end

    // Datapath registers
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            count       <= '0;
            quoReg      <= '0;
            remReg      <= '0;
            divisorReg  <= '0;
            dividendRaw <= '0;
            negQuo      <= 1'b0;
            negRem      <= 1'b0;
            hi          <= '0;
            lo          <= '0;
        end else begin
            if (accept) begin
                count       <= CNT_LAST;
                quoReg      <= aMag;
                remReg      <= '0;
                divisorReg  <= bMag;
                dividendRaw <= a;
                negQuo      <= signed_div && (a[WIDTH-1] ^ b[WIDTH-1]);
                negRem      <= signed_div && a[WIDTH-1];
            end else if (state == BUSY) begin
                if (annul) begin
                    count <= '0;
                end else begin
                    quoReg <= quoNext;
                    remReg <= remNext;
                    if (!lastStep) begin
                        count <= count - 1'b1;
                    end
                end
            end
            if (finish) begin
                hi <= hiResult;
                lo <= loResult;
            end
        end
    end

endmodule

// File: tb/tb_div_unit.sv
module tb_div_unit;

    logic        clk;
    logic        rst;
    logic        start;
    logic        signedDiv;
    logic        annul;
    logic [31:0] a;
    logic [31:0] b;
    logic        stall;
    logic        ready;
    logic [31:0] hi;
    logic [31:0] lo;

    int compared   = 0;
    int mismatched = 0;

    div_unit #(.WIDTH(32)) dut (
        .clk        (clk),
        .rst        (rst),
        .start      (start),
        .signed_div (signedDiv),
        .annul      (annul),
        .a          (a),
        .b          (b),
        .stall      (stall),
        .ready      (ready),
        .hi         (hi),
        .lo         (lo)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Stimulus only: issues one divide with start held until ready, then drops
    // start one cycle after the DONE cycle. Cycle 0 is the request cycle.
    task automatic runDiv(input logic [31:0] aIn, input logic [31:0] bIn, input logic sgn,
                          output int latency, output int stallCount, output logic gotReady);
        @(negedge clk);
        a = aIn; b = bIn; signedDiv = sgn; start = 1'b1; annul = 1'b0;
        latency = 0; stallCount = 0; gotReady = 1'b0;
        for (int c = 0; c < 100; c++) begin
            #1;
            if (stall === 1'b1) stallCount++;
            if (ready === 1'b1) begin
                gotReady = 1'b1;
                latency  = c;
                break;
            end
            @(negedge clk);
        end
        @(negedge clk);
        start = 1'b0;
        #1;
    endtask

    task automatic test_reset;
        rst = 1'b0; start = 1'b1; annul = 1'b0; signedDiv = 1'b0; a = 32'd9; b = 32'd3;
        repeat (3) @(negedge clk);
        #1;
        compared++; if (stall !== 1'b0) begin mismatched++; $display("FAIL reset_stall got=%b want=0", stall); end
        compared++; if (ready !== 1'b0) begin mismatched++; $display("FAIL reset_ready got=%b want=0", ready); end
        compared++; if (hi !== 32'h0) begin mismatched++; $display("FAIL reset_hi got=%h want=00000000", hi); end
        compared++; if (lo !== 32'h0) begin mismatched++; $display("FAIL reset_lo got=%h want=00000000", lo); end
        @(negedge clk);
        start = 1'b0; rst = 1'b1;
        @(negedge clk); #1;
        compared++; if (stall !== 1'b0) begin mismatched++; $display("FAIL reset_release_stall got=%b want=0", stall); end
    endtask

    task automatic test_divu;
        int lat, st; logic got;
        runDiv(32'd100, 32'd7, 1'b0, lat, st, got);
        compared++; if (got !== 1'b1) begin mismatched++; $display("FAIL divu_ready_seen got=%b want=1", got); end
        compared++; if (st != 33) begin mismatched++; $display("FAIL divu_stall_cycles got=%0d want=33", st); end
        compared++; if (lat != 33) begin mismatched++; $display("FAIL divu_latency got=%0d want=33", lat); end
        compared++; if (lo !== 32'd14) begin mismatched++; $display("FAIL divu_lo got=%0d want=14", lo); end
        compared++; if (hi !== 32'd2) begin mismatched++; $display("FAIL divu_hi got=%0d want=2", hi); end
        // One-cycle pulse, and the start held through DONE did not restart.
        compared++; if (ready !== 1'b0) begin mismatched++; $display("FAIL divu_ready_pulse got=%b want=0", ready); end
        compared++; if (stall !== 1'b0) begin mismatched++; $display("FAIL divu_no_restart got=%b want=0", stall); end

        runDiv(32'hFFFF_FFFF, 32'h10, 1'b0, lat, st, got);
        compared++; if (lo !== 32'h0FFF_FFFF) begin mismatched++; $display("FAIL divu_big_lo got=%h want=0fffffff", lo); end
        compared++; if (hi !== 32'hF) begin mismatched++; $display("FAIL divu_big_hi got=%h want=0000000f", hi); end
    endtask

    task automatic test_div_signed;
        int lat, st; logic got;
        runDiv(32'hFFFF_FFF9, 32'd2, 1'b1, lat, st, got);
        compared++; if (lo !== 32'hFFFF_FFFD) begin mismatched++; $display("FAIL div_m7_2_lo got=%h want=fffffffd", lo); end
        compared++; if (hi !== 32'hFFFF_FFFF) begin mismatched++; $display("FAIL div_m7_2_hi got=%h want=ffffffff", hi); end
        runDiv(32'd7, 32'hFFFF_FFFE, 1'b1, lat, st, got);
        compared++; if (lo !== 32'hFFFF_FFFD) begin mismatched++; $display("FAIL div_7_m2_lo got=%h want=fffffffd", lo); end
        compared++; if (hi !== 32'd1) begin mismatched++; $display("FAIL div_7_m2_hi got=%h want=00000001", hi); end
        runDiv(32'hFFFF_FFF9, 32'hFFFF_FFFE, 1'b1, lat, st, got);
        compared++; if (lo !== 32'd3) begin mismatched++; $display("FAIL div_m7_m2_lo got=%h want=00000003", lo); end
        compared++; if (hi !== 32'hFFFF_FFFF) begin mismatched++; $display("FAIL div_m7_m2_hi got=%h want=ffffffff", hi); end
    endtask

    task automatic test_overflow;
        int lat, st; logic got;
        runDiv(32'h8000_0000, 32'hFFFF_FFFF, 1'b1, lat, st, got);
        compared++; if (lo !== 32'h8000_0000) begin mismatched++; $display("FAIL ovf_lo got=%h want=80000000", lo); end
        compared++; if (hi !== 32'h0) begin mismatched++; $display("FAIL ovf_hi got=%h want=00000000", hi); end
        compared++; if (lat != 33) begin mismatched++; $display("FAIL ovf_latency got=%0d want=33", lat); end
    endtask

    task automatic test_div_zero;
        int lat, st; logic got;
        runDiv(32'd5, 32'd0, 1'b0, lat, st, got);
        compared++; if (lat != 2) begin mismatched++; $display("FAIL dz_latency got=%0d want=2", lat); end
        compared++; if (st != 2) begin mismatched++; $display("FAIL dz_stall_cycles got=%0d want=2", st); end
        compared++; if (lo !== 32'hFFFF_FFFF) begin mismatched++; $display("FAIL dz_lo got=%h want=ffffffff", lo); end
        compared++; if (hi !== 32'd5) begin mismatched++; $display("FAIL dz_hi got=%h want=00000005", hi); end
        runDiv(32'hFFFF_FFFB, 32'd0, 1'b1, lat, st, got);
        compared++; if (lo !== 32'hFFFF_FFFF) begin mismatched++; $display("FAIL dz_signed_lo got=%h want=ffffffff", lo); end
        compared++; if (hi !== 32'hFFFF_FFFB) begin mismatched++; $display("FAIL dz_signed_hi got=%h want=fffffffb", hi); end
    endtask

    task automatic test_early_out;
        int lat, st; logic got;
        int expLat;
`ifdef DIV_EARLY_OUT_EN
        expLat = 2;
`else
        expLat = 33;
`endif
        runDiv(32'd3, 32'd9, 1'b0, lat, st, got);
        compared++; if (lat != expLat) begin mismatched++; $display("FAIL early_latency got=%0d want=%0d", lat, expLat); end
        compared++; if (lo !== 32'd0) begin mismatched++; $display("FAIL early_lo got=%h want=00000000", lo); end
        compared++; if (hi !== 32'd3) begin mismatched++; $display("FAIL early_hi got=%h want=00000003", hi); end
    endtask

    task automatic test_annul;
        int lat, st; logic got;
        logic sawReady;
        runDiv(32'd100, 32'd7, 1'b0, lat, st, got);   // hi=2, lo=14 as reference
        @(negedge clk);
        a = 32'h1234; b = 32'h10; signedDiv = 1'b0; start = 1'b1;
        repeat (10) @(negedge clk);                    // now in BUSY cycle 10
        annul = 1'b1; start = 1'b0;
        #1;
        compared++; if (stall !== 1'b1) begin mismatched++; $display("FAIL annul_busy_stall got=%b want=1", stall); end
        @(negedge clk);
        annul = 1'b0;
        #1;
        compared++; if (stall !== 1'b0) begin mismatched++; $display("FAIL annul_idle_stall got=%b want=0", stall); end
        compared++; if (hi !== 32'd2) begin mismatched++; $display("FAIL annul_hi_kept got=%h want=00000002", hi); end
        compared++; if (lo !== 32'd14) begin mismatched++; $display("FAIL annul_lo_kept got=%h want=0000000e", lo); end
        sawReady = 1'b0;
        for (int c = 0; c < 40; c++) begin
            @(negedge clk); #1;
            if (ready === 1'b1) sawReady = 1'b1;
        end
        compared++; if (sawReady !== 1'b0) begin mismatched++; $display("FAIL annul_no_ready got=%b want=0", sawReady); end
    endtask

    task automatic test_annul_priority;
        @(negedge clk);
        a = 32'd50; b = 32'd5; signedDiv = 1'b0; start = 1'b1; annul = 1'b1;
        #1;
        compared++; if (stall !== 1'b0) begin mismatched++; $display("FAIL prio_stall got=%b want=0", stall); end
        @(negedge clk);
        start = 1'b0; annul = 1'b0;
        #1;
        compared++; if (stall !== 1'b0) begin mismatched++; $display("FAIL prio_not_accepted got=%b want=0", stall); end
    endtask

    task automatic test_reset_mid;
        int lat, st; logic got;
        @(negedge clk);
        a = 32'd100; b = 32'd7; signedDiv = 1'b0; start = 1'b1; annul = 1'b0;
        repeat (5) @(negedge clk);                     // BUSY cycle 5
        rst = 1'b0;
        #1;
        compared++; if (stall !== 1'b0) begin mismatched++; $display("FAIL rstmid_stall got=%b want=0", stall); end
        compared++; if (ready !== 1'b0) begin mismatched++; $display("FAIL rstmid_ready got=%b want=0", ready); end
        compared++; if (hi !== 32'h0) begin mismatched++; $display("FAIL rstmid_hi got=%h want=00000000", hi); end
        compared++; if (lo !== 32'h0) begin mismatched++; $display("FAIL rstmid_lo got=%h want=00000000", lo); end
        @(negedge clk);
        start = 1'b0; rst = 1'b1;
        @(negedge clk); #1;
        compared++; if (stall !== 1'b0) begin mismatched++; $display("FAIL rstmid_release got=%b want=0", stall); end
        runDiv(32'd100, 32'd7, 1'b0, lat, st, got);
        compared++; if (lo !== 32'd14) begin mismatched++; $display("FAIL rstmid_recover_lo got=%0d want=14", lo); end
        compared++; if (lat != 33) begin mismatched++; $display("FAIL rstmid_recover_latency got=%0d want=33", lat); end
    endtask

    task automatic test_back_to_back;
        int lat, st; logic got;
        runDiv(32'd81, 32'd9, 1'b0, lat, st, got);
        compared++; if (lo !== 32'd9) begin mismatched++; $display("FAIL b2b_first_lo got=%0d want=9", lo); end
        compared++; if (hi !== 32'd0) begin mismatched++; $display("FAIL b2b_first_hi got=%0d want=0", hi); end
        runDiv(32'd1000, 32'd33, 1'b0, lat, st, got);
        compared++; if (lo !== 32'd30) begin mismatched++; $display("FAIL b2b_second_lo got=%0d want=30", lo); end
        compared++; if (hi !== 32'd10) begin mismatched++; $display("FAIL b2b_second_hi got=%0d want=10", hi); end
    endtask

    initial begin
        test_reset;
        test_divu;
        test_div_signed;
        test_overflow;
        test_div_zero;
        test_early_out;
        test_annul;
        test_annul_priority;
        test_reset_mid;
        test_back_to_back;
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
        $finish;
    end

endmodule
